regfile_exec_unit: RTL and testbench

- Parametrised register file with a built-in sequential execute engine.
- A command (rs1, rs2, rd, op) is accepted over a valid/ready handshake. The engine reads both operands, computes the ALU result with carry, and writes it back to rd through a fixed 4-state FSM.
- A separate host write port (touchscreen-driven register load) and a combinational test read port (display scan) run alongside the engine.
- Successor to the fixed 32x32 regfile + adder display pairing: width and depth are generalised, plus opcode select, hazard-free writeback sequencing and carry/error flags.

---
 rtl/regfile_exec_unit_if.sv | 29 ++
 rtl/regfile_exec_unit.sv | 175 +++++++++++++++++
 tb/tb_regfile_exec_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_exec_unit_if.sv
// Command handshake and host write bus for the register-file execute unit.
// The master side issues commands and host loads; the slave side is the engine.
interface regfile_exec_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;

  logic              host_wen;
  logic [ADDR_W-1:0] host_waddr;
  logic [DATA_W-1:0] host_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
    output host_wen, host_waddr, host_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
    input  host_wen, host_waddr, host_wdata,
    output cmd_ready
  );
endinterface

// File: rtl/regfile_exec_unit.sv
// Register file with a four-state sequential execute engine.
// A command reads two registers, runs the ALU and writes rd back; a host
// write port and a combinational display read port run alongside.
module regfile_exec_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_exec_unit_if.slave  bus,
  input  logic [ADDR_W-1:0]   test_addr,
  output logic [DATA_W-1:0]   test_data,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [DATA_W-1:0]   result,
  output logic                cout,
  output logic                err,
  output logic                done,
  output logic                busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLTU = 3'd5,
    OP_PASS = 3'd6,
    OP_ILL  = 3'd7
  } op_t;

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;

  logic [DATA_W-1:0] regs [0:DEPTH-1];

  // Address 0 is hard-wired to zero when ZERO_REG is set.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Read ports: the array itself is never written at address 0, but the
  // mask keeps reads correct independent of that.
  logic [DATA_W-1:0] rd_rs1;
  logic [DATA_W-1:0] rd_rs2;

  assign rd_rs1    = is_zero_addr(rs1_q)     ? '0 : regs[rs1_q];
  assign rd_rs2    = is_zero_addr(rs2_q)     ? '0 : regs[rs2_q];
  assign test_data = is_zero_addr(test_addr) ? '0 : regs[test_addr];

  assign bus.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);

  // Write enables for the two register-file writers.
  logic host_we;
  logic wb_we;

  assign host_we = bus.host_wen && !is_zero_addr(bus.host_waddr);
  assign wb_we   = (state == S_WB) && !err && !is_zero_addr(rd_q);

  // ALU on the latched operands; subtraction reuses the adder as a + ~b + 1.
  logic [DATA_W-1:0] alu_b;
  logic              alu_cin;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;

  assign alu_b   = (op_q == OP_SUB) ? ~op_b : op_b;
  assign alu_cin = (op_q == OP_SUB);
  assign alu_sum = {1'b0, op_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, alu_cin};

  // Opcode decode of the ALU result and carry.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    alu_res  = '0;
    alu_cout = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res  = alu_sum[DATA_W-1:0];
        alu_cout = alu_sum[DATA_W];
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      OP_PASS: alu_res = op_a;
      OP_ILL:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Register file storage: host write plus engine writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is cleared on reset because the architecture
      // requires all registers to read 0 afterwards; a plain RAM would not
      // be reset, and doing so here forces the array into flops.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i[ADDR_W-1:0]] <= '0;
      end
    end else begin
      if (host_we) begin
        regs[bus.host_waddr] <= bus.host_wdata;
      end
      // Engine writeback is issued last so it wins on an address collision.
      if (wb_we) begin
        regs[rd_q] <= result;
      end
    end
  end

  // Command sequencer: IDLE -> READ -> EXEC -> WB, with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      cout   <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the READ state samples
      // the array as it was before any write landing on the same edge.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= op_t'(bus.cmd_op);
            rs1_q <= bus.cmd_rs1;
            rs2_q <= bus.cmd_rs2;
            rd_q  <= bus.cmd_rd;
            state <= S_READ;
          end
        end
        S_READ: begin
          op_a  <= rd_rs1;
          op_b  <= rd_rs2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_res;
          cout   <= alu_cout;
          err    <= (op_q == OP_ILL);
          done   <= 1'b1;
          state  <= S_WB;
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Self-checking bench for regfile_exec_unit: directed corner cases followed
// by randomized commands, scored against a behavioural register-file model.
module tb_regfile_exec_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] test_addr;
  logic [DATA_W-1:0] test_data;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic              cout;
  logic              err;
  logic              done;
  logic              busy;

  always #5 clk = ~clk;

  regfile_exec_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_exec_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .test_addr (test_addr),
    .test_data (test_data),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result),
    .cout      (cout),
    .err       (err),
    .done      (done),
    .busy      (busy)
  );

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              c;
    logic              e;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int                cyc;
  } exp_t;

  exp_t              sb [$];
  logic [DATA_W-1:0] model [0:31];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  logic [ADDR_W-1:0] pend_rd;
  logic [DATA_W-1:0] pend_val;
  bit                pend_we;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the operation table with plain arithmetic.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    exp_t r;
    logic [63:0] s;
    r.a = a; r.b = b; r.res = '0; r.c = 1'b0; r.e = 1'b0; r.cyc = 0;
    case (op)
      3'd0: begin s = 64'(a) + 64'(b); r.res = s[31:0]; r.c = s[32]; end
      3'd1: begin r.res = a - b; r.c = (a >= b); end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: r.res = (a < b) ? 32'd1 : 32'd0;
      3'd6: r.res = a;
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    if (addr != 0) model[addr] = data;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.host_wen   = 1'b1;
    bus.host_waddr = addr;
    bus.host_wdata = data;
    tick();
    bus.host_wen = 1'b0;
    model_write(addr, data);
  endtask

  // Present a command and return just after its accept edge.
  task automatic accept(input logic [2:0] op, input logic [ADDR_W-1:0] rs1,
                        input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd);
    exp_t e;
    int   n = 0;
    bus.cmd_op    = op;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_rd    = rd;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_at_issue", 64'(bus.cmd_ready), 64'd1);
    e = ref_op(op, model[rs1], model[rs2]);
    tick();
    e.cyc = cyc;
    bus.cmd_valid = 1'b0;
    sb.push_back(e);
    pend_rd  = rd;
    pend_val = e.res;
    pend_we  = !e.e;
  endtask

  task automatic finish_cmd(input int n);
    repeat (n) tick();
    if (pend_we) model_write(pend_rd, pend_val);
  endtask

  task automatic check_reg(input logic [ADDR_W-1:0] addr);
    test_addr = addr;
    @(negedge clk);
    check($sformatf("test_data_reg%0d", addr), 64'(test_data), 64'(model[addr]));
  endtask

  task automatic run(input logic [2:0] op, input logic [ADDR_W-1:0] rs1,
                     input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd);
    accept(op, rs1, rs2, rd);
    finish_cmd(3);
    check_reg(rd);
  endtask

  task automatic check_cleared();
    @(negedge clk);
    check("clr_result", 64'(result), 64'd0);
    check("clr_cout", 64'(cout), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    check("clr_op_a", 64'(op_a), 64'd0);
    check("clr_op_b", 64'(op_b), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse consumes one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("cout", 64'(cout), 64'(e.c));
          check("err", 64'(err), 64'(e.e));
          check("op_a", 64'(op_a), 64'(e.a));
          check("op_b", 64'(op_b), 64'(e.b));
          check("done_latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [2:0]        rop;
    logic [ADDR_W-1:0] ra, rb, rd;

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_rd     = '0;
    bus.host_wen   = 1'b0;
    bus.host_waddr = '0;
    bus.host_wdata = '0;
    test_addr      = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    check_cleared();
    check_reg(5'd7);

    // ADD with carry out and zero result.
    host_write(5'd3, 32'hFFFF_FFFF);
    host_write(5'd4, 32'h0000_0001);
    run(3'd0, 5'd3, 5'd4, 5'd5);

    // SUB both ways round.
    host_write(5'd3, 32'd5);
    host_write(5'd4, 32'd7);
    run(3'd1, 5'd3, 5'd4, 5'd6);
    run(3'd1, 5'd4, 5'd3, 5'd6);

    // Zero register ignores engine and host writes.
    run(3'd0, 5'd3, 5'd4, 5'd0);
    host_write(5'd0, 32'h1234);
    check_reg(5'd0);

    // Illegal opcode: err set, no writeback; a legal op clears err.
    host_write(5'd8, 32'hAA);
    run(3'd7, 5'd3, 5'd4, 5'd8);
    run(3'd2, 5'd3, 5'd4, 5'd9);

    // Host write to rd on the writeback edge: engine result wins.
    host_write(5'd10, 32'h11);
    accept(3'd0, 5'd3, 5'd4, 5'd10);
    tick();
    tick();
    bus.host_wen = 1'b1; bus.host_waddr = 5'd10; bus.host_wdata = 32'hDEAD_BEEF;
    tick();
    bus.host_wen = 1'b0;
    model_write(5'd10, 32'hDEAD_BEEF);
    finish_cmd(0);
    check_reg(5'd10);

    // Host write to another address on the writeback edge: both land.
    accept(3'd4, 5'd3, 5'd4, 5'd11);
    tick();
    tick();
    bus.host_wen = 1'b1; bus.host_waddr = 5'd12; bus.host_wdata = 32'h0000_CAFE;
    tick();
    bus.host_wen = 1'b0;
    model_write(5'd12, 32'h0000_CAFE);
    finish_cmd(0);
    check_reg(5'd11);
    check_reg(5'd12);

    // Host write to rs1 during READ: operand keeps the old value.
    accept(3'd6, 5'd3, 5'd4, 5'd13);
    bus.host_wen = 1'b1; bus.host_waddr = 5'd3; bus.host_wdata = 32'h77;
    tick();
    bus.host_wen = 1'b0;
    model_write(5'd3, 32'h77);
    finish_cmd(2);
    check_reg(5'd13);
    check_reg(5'd3);

    // Reset during EXEC aborts the command.
    accept(3'd0, 5'd3, 5'd4, 5'd14);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(sb.pop_back());
    for (int i = 0; i < 32; i++) model[i] = '0;
    check_cleared();
    check_reg(5'd14);
    check_reg(5'd13);

    // cmd_valid held through the busy window: exactly one command accepted.
    host_write(5'd3, 32'd9);
    host_write(5'd4, 32'd2);
    accept(3'd0, 5'd3, 5'd4, 5'd15);
    bus.cmd_valid = 1'b1;
    finish_cmd(3);
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    check_cleared_busy: begin
      @(negedge clk);
      check("single_accept_busy", 64'(busy), 64'd0);
    end
    check_reg(5'd15);

    // Randomized commands with interleaved host loads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        ra = 5'($urandom_range(0, 31));
        host_write(ra, rand_data());
      end
      rop = 3'($urandom_range(0, 7));
      ra  = 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      run(rop, ra, rb, rd);
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
